// File: rtl/fft_pkg.sv
// Shared definitions for the FFT index reorder block.
//   IDX_WIDTH   : default index width (frame length 2^IDX_WIDTH)
//   idx_t       : index type at the default width
//   gen_state_e : sweep generator states
//   bitrev      : reference bit-reverse for any width up to 16
package fft_pkg;

  localparam int IDX_WIDTH = 9;

  typedef logic [IDX_WIDTH-1:0] idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  // Reverses the low w bits of x; bits at or above w come back as 0.
  function automatic logic [15:0] bitrev(input logic [15:0] x, input int unsigned w);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_index_reorder_if.sv
// Signal bundle for fft_index_reorder.
//   slave  : the reorder unit (takes indices and gen_start, drives the results)
//   master : the user (drives indices and gen_start, takes the results)
interface fft_index_reorder_if #(
  parameter int IDX_WIDTH = fft_pkg::IDX_WIDTH
);
  logic [IDX_WIDTH-1:0] original_idx;
  logic [IDX_WIDTH-1:0] reorder_idx;
  logic                 in_valid;
  logic [IDX_WIDTH-1:0] reorder_idx_q;
  logic                 out_valid;
  logic                 gen_start;
  logic                 gen_busy;
  logic [IDX_WIDTH-1:0] gen_nat_idx;
  logic [IDX_WIDTH-1:0] gen_rev_idx;
  logic                 gen_valid;
  logic                 gen_done;

  modport slave (
    input  original_idx, in_valid, gen_start,
    output reorder_idx, reorder_idx_q, out_valid,
           gen_busy, gen_nat_idx, gen_rev_idx, gen_valid, gen_done
  );

  modport master (
    output original_idx, in_valid, gen_start,
    input  reorder_idx, reorder_idx_q, out_valid,
           gen_busy, gen_nat_idx, gen_rev_idx, gen_valid, gen_done
  );
endinterface

// File: rtl/bitrev_net.sv
// Pure bit-reversal wiring: o_idx[i] = i_idx[W-1-i].
//   i_idx : natural-order index
//   o_idx : bit-reversed index
module bitrev_net #(
  parameter int W = fft_pkg::IDX_WIDTH
) (
  input  logic [W-1:0] i_idx,
  output logic [W-1:0] o_idx
);
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign o_idx[gi] = i_idx[W-1-gi];
  end
endmodule

// File: rtl/fft_index_reorder.sv
// Bit-reversal index unit for the radix-2 FFT reorder buffer.
// Three paths: combinational mapping, registered mapping with valid,
// and a self-running generator that sweeps every index of a frame.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fft_index_reorder_if.slave (indices, valids, generator controls)
module fft_index_reorder
  import fft_pkg::*;
#(
  parameter int IDX_WIDTH = fft_pkg::IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  fft_index_reorder_if.slave     bus
);

  localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;

  // Direct / registered path
  logic [IDX_WIDTH-1:0] w_rev;
  logic [IDX_WIDTH-1:0] r_rev_q;
  logic                 r_out_valid;

  bitrev_net #(.W(IDX_WIDTH)) u_rev_direct (
    .i_idx (bus.original_idx),
    .o_idx (w_rev)
  );

  // reorder_idx_q updates every edge regardless of in_valid; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rev_q     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rev_q     <= w_rev;
      r_out_valid <= bus.in_valid;
    end
  end

  assign bus.reorder_idx   = w_rev;
  assign bus.reorder_idx_q = r_rev_q;
  assign bus.out_valid     = r_out_valid;

  // Sweep generator
  gen_state_e           r_state, w_state_next;
  logic [IDX_WIDTH-1:0] r_cnt, w_cnt_next;
  logic                 w_run;
  logic [IDX_WIDTH-1:0] w_gen_nat;
  logic [IDX_WIDTH-1:0] w_gen_rev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // gen_start is only looked at in IDLE, so pulses during RUN (including the
  // final step) never restart the sweep.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (bus.gen_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_cnt == CNT_MAX) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  // Force outputs to zero outside a sweep.
  assign w_gen_nat = w_run ? r_cnt : '0;

  bitrev_net #(.W(IDX_WIDTH)) u_rev_gen (
    .i_idx (w_gen_nat),
    .o_idx (w_gen_rev)
  );

  assign bus.gen_busy    = w_run;
  assign bus.gen_valid   = w_run;
  assign bus.gen_nat_idx = w_gen_nat;
  assign bus.gen_rev_idx = w_gen_rev;
  assign bus.gen_done    = w_run && (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_fft_index_reorder.sv
module tb_fft_index_reorder;
  import fft_pkg::*;

  logic clk;
  logic rst;

  fft_index_reorder_if #(.IDX_WIDTH(9)) bus ();

  fft_index_reorder #(.IDX_WIDTH(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Independent model: shift bits of x out LSB-first into r MSB-first.
  function automatic idx_t model_rev(input idx_t x);
    idx_t r;
    r = '0;
    for (int i = 0; i < 9; i++) r = idx_t'((r << 1) | ((x >> i) & 9'd1));
    return r;
  endfunction

  // {valid, busy, done, nat, rev} packed for one compare per step.
  function automatic logic [31:0] gen_vec();
    return 32'({bus.gen_valid, bus.gen_busy, bus.gen_done, bus.gen_nat_idx, bus.gen_rev_idx});
  endfunction

  function automatic logic [31:0] exp_vec(input logic v, input logic d, input idx_t n);
    return 32'({v, v, d, n, (v ? model_rev(n) : idx_t'(0))});
  endfunction

  task automatic comb_chk(input string tag, input idx_t x, input idx_t exp);
    bus.original_idx = x;
    #1;
    chk(tag, 32'(bus.reorder_idx), 32'(exp));
  endtask

  // Runs a full sweep from a negedge in IDLE; optionally pulses gen_start
  // mid-sweep and/or on the gen_done step.
  task automatic run_sweep(input string tag, input bit mid_start, input bit done_start);
    bus.gen_start = 1'b1;
    @(negedge clk);
    bus.gen_start = 1'b0;
    for (int k = 0; k < 512; k++) begin
      chk($sformatf("%s_step%0d", tag, k), gen_vec(), exp_vec(1'b1, (k == 511), idx_t'(k)));
      if (k == 2) chk({tag, "_step2_rev"}, 32'(bus.gen_rev_idx), 32'd128);
      bus.gen_start = (mid_start && k == 200) || (done_start && k == 511);
      @(negedge clk);
      bus.gen_start = 1'b0;
    end
    chk({tag, "_end_idle"}, gen_vec(), exp_vec(1'b0, 1'b0, '0));
    @(negedge clk);
    chk({tag, "_end_idle2"}, gen_vec(), exp_vec(1'b0, 1'b0, '0));
  endtask

  initial begin
    idx_t prev_idx;
    logic prev_v;
    idx_t r_idx;

    rst              = 1'b1;
    bus.original_idx = '0;
    bus.in_valid     = 1'b0;
    bus.gen_start    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q",   32'(bus.reorder_idx_q), 32'd0);
    chk("rst_ov",  32'(bus.out_valid), 32'd0);
    chk("rst_gen", gen_vec(), exp_vec(1'b0, 1'b0, '0));
    rst = 1'b0;

    // Combinational corners and pairs
    comb_chk("comb_0",   9'd0,   9'd0);
    comb_chk("comb_511", 9'd511, 9'd511);
    comb_chk("comb_1",   9'd1,   9'd256);
    comb_chk("comb_256", 9'd256, 9'd1);
    comb_chk("comb_90",  9'd90,  9'd180);
    comb_chk("comb_180", 9'd180, 9'd90);
    comb_chk("comb_172", 9'd172, 9'd106);

    // Registered path
    @(negedge clk);
    bus.original_idx = 9'd3;
    bus.in_valid     = 1'b1;
    @(negedge clk);
    chk("reg_q_3",  32'(bus.reorder_idx_q), 32'd384);
    chk("reg_ov_1", 32'(bus.out_valid), 32'd1);
    bus.original_idx = 9'd5;
    bus.in_valid     = 1'b0;
    @(negedge clk);
    chk("reg_ov_0", 32'(bus.out_valid), 32'd0);
    chk("reg_q_5",  32'(bus.reorder_idx_q), 32'd320);

    // Sweeps
    run_sweep("sweep",      1'b0, 1'b0);
    run_sweep("sweep_mid",  1'b1, 1'b0);
    run_sweep("sweep_done", 1'b0, 1'b1);

    // Reset mid-sweep at step 100
    bus.gen_start = 1'b1;
    @(negedge clk);
    bus.gen_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_at100", gen_vec(), exp_vec(1'b1, 1'b0, idx_t'(100)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_gen0", gen_vec(), exp_vec(1'b0, 1'b0, '0));
    repeat (3) @(negedge clk);
    chk("abort_stay_idle", gen_vec(), exp_vec(1'b0, 1'b0, '0));
    run_sweep("sweep_after_rst", 1'b0, 1'b0);

    // Random indices through both paths
    prev_idx = '0;
    prev_v   = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      r_idx            = idx_t'($urandom_range(0, 511));
      bus.original_idx = r_idx;
      bus.in_valid     = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd_comb_%0d", i), 32'(bus.reorder_idx), 32'(model_rev(r_idx)));
      if (i > 0) begin
        chk($sformatf("rnd_q_%0d", i),  32'(bus.reorder_idx_q), 32'(model_rev(prev_idx)));
        chk($sformatf("rnd_ov_%0d", i), 32'(bus.out_valid), 32'(prev_v));
      end
      prev_idx = r_idx;
      prev_v   = bus.in_valid;
      @(negedge clk);
    end
    chk("rnd_q_last",  32'(bus.reorder_idx_q), 32'(model_rev(prev_idx)));
    chk("rnd_ov_last", 32'(bus.out_valid), 32'(prev_v));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_index_reorder.md
# fft_index_reorder

Bit-reversal index unit for the radix-2 FFT datapath. It maps a natural-order sample index to its bit-reversed position, so FFT output can be written to, or read from, the reorder buffer in natural order. It has three paths: a combinational mapping, a one-cycle registered mapping with valid, and a self-running sequence generator that sweeps every index of a frame.

## Interface
Parameters:
- IDX_WIDTH, default 9: index width in bits; frame length is 2^IDX_WIDTH (512). Legal range 1–16.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- original_idx  in  IDX_WIDTH  natural-order index.
- reorder_idx  out  IDX_WIDTH  combinational bit-reverse of original_idx.
- in_valid  in  1  qualifies original_idx for the registered path.
- reorder_idx_q  out  IDX_WIDTH  registered bit-reverse of original_idx.
- out_valid  out  1  reorder_idx_q is valid.
- gen_start  in  1  one-cycle pulse that starts a full-frame sweep.
- gen_busy  out  1  a sweep is in progress.
- gen_nat_idx  out  IDX_WIDTH  natural index of the current sweep step.
- gen_rev_idx  out  IDX_WIDTH  bit-reverse of gen_nat_idx.
- gen_valid  out  1  gen_nat_idx and gen_rev_idx are valid this cycle.
- gen_done  out  1  one-cycle pulse on the last sweep step.

## Operation
- Mapping: reorder_idx[i] = original_idx[IDX_WIDTH-1-i] for every i. This is pure wiring, with no arithmetic.
- The mapping is an involution, so bitrev(bitrev(x)) = x. Palindromic patterns map to themselves; 0 maps to 0 and all-ones maps to all-ones.
- Registered path: each edge loads reorder_idx_q with bitrev(original_idx) and out_valid with in_valid. When in_valid is low, reorder_idx_q still updates; consumers gate it with out_valid.
- Generator FSM has two states, IDLE and RUN.
  - IDLE → RUN on gen_start: the counter loads 0 and gen_busy rises.
  - In RUN, each cycle presents the counter value as gen_nat_idx, with its bit-reverse on gen_rev_idx, and asserts gen_valid. The counter then increments.
  - When the counter equals 2^IDX_WIDTH−1, gen_done asserts for that cycle, and the next state is IDLE with the counter cleared to 0.
  - gen_start while in RUN is ignored; the sweep is not restarted.
  - gen_start on the same cycle as gen_done is also ignored. A new sweep needs a pulse while in IDLE.
- The generator and the registered path are independent and may run simultaneously.
- While gen_valid is low, gen_nat_idx and gen_rev_idx hold 0.

## Timing
- reorder_idx: zero latency, combinational from original_idx.
- reorder_idx_q and out_valid: one-cycle latency.
- Generator:
  - gen_start sampled on edge N gives the first gen_valid (index 0) on cycle N+1.
  - The sweep lasts exactly 2^IDX_WIDTH cycles with no bubbles.
  - gen_done coincides with the final step (natural index 2^IDX_WIDTH−1).
  - gen_busy is high for exactly the cycles where gen_valid is high.
- Reset, sampled on a clock edge, forces:
  - reorder_idx_q=0, out_valid=0;
  - FSM to IDLE, counter=0;
  - gen_busy=0, gen_valid=0, gen_done=0, gen_nat_idx=0, gen_rev_idx=0.
- Reset mid-sweep aborts the sweep immediately; no gen_done is produced.
- reorder_idx is unaffected by reset.

## Structure
- Shared package fft_pkg holds the IDX_WIDTH default, an idx_t typedef, and a bitrev function parameterized by width.
- The sub-module bitrev_net is pure combinational and is instantiated twice, once for the direct/registered path and once for the generator.
- The generator FSM and counter live in the top level; no further hierarchy is needed.

## Test plan
- Combinational corner values:
  - original_idx=0 → reorder_idx=0.
  - original_idx=511 → reorder_idx=511.
  - original_idx=1 → reorder_idx=256.
  - original_idx=256 → reorder_idx=1.
- Combinational pairs:
  - original_idx=90 (001011010) → reorder_idx=180 (010110100).
  - original_idx=180 → reorder_idx=90.
  - original_idx=172 → reorder_idx=106.
- Registered path: in_valid=1 with original_idx=3 → next cycle reorder_idx_q=384 and out_valid=1. Drop in_valid → out_valid=0 the following cycle.
- Full sweep: pulse gen_start →
  - 512 consecutive gen_valid cycles;
  - step k has gen_nat_idx=k and gen_rev_idx=bitrev(k);
  - step 2 shows gen_rev_idx=128;
  - gen_done on step 511 only; gen_busy falls on the next cycle.
- Restart rules: gen_start pulsed mid-sweep → no restart and still 512 steps; gen_start on the gen_done cycle → ignored.
- Reset handling:
  - rst asserted at sweep step 100 → all generator outputs 0 on the next cycle, and no gen_done.
  - A fresh gen_start then sweeps from 0.
- Random check: 1000 random indices through both the combinational and registered paths, compared against a scoreboard bit-reverse model.
